// File: rtl/cpu_prog_sequencer_if.sv
// cpu_prog_sequencer_if
//   Bundles the host load/start port and the cpu-facing outputs of the
//   program sequencer.
//   Parameter: ADDR_W - program store address width.
//   Host -> sequencer : load_en, load_addr, load_data, start
//   Sequencer -> host : busy, done, overflow, pc
//   Sequencer -> cpu  : cpu_reset, cpu_in
//
// Handshake: there is no valid/ready pair. load_en and start are single-cycle
// level requests sampled on the rising edge. The sequencer acts on them only
// while busy is low (IDLE/DONE) and silently drops them while busy is high,
// so a host must see busy==0 before relying on a request taking effect.
interface cpu_prog_sequencer_if #(
  parameter int ADDR_W = 4
);
  logic              load_en;
  logic [ADDR_W-1:0] load_addr;
  logic [7:0]        load_data;
  logic              start;
  logic              busy;
  logic              done;
  logic              overflow;
  logic [ADDR_W-1:0] pc;
  logic              cpu_reset;
  logic [7:0]        cpu_in;

  modport master (
    output load_en, load_addr, load_data, start,
    input  busy, done, overflow, pc, cpu_reset, cpu_in
  );

  modport slave (
    input  load_en, load_addr, load_data, start,
    output busy, done, overflow, pc, cpu_reset, cpu_in
  );
endinterface

// File: rtl/cpu_prog_sequencer.sv
// cpu_prog_sequencer
//   Instruction sequencer for the 8-bit cpu. Holds a loadable program store
//   of 2**ADDR_W bytes. On start it pulses cpu_reset for one cycle and then
//   streams one byte per clock into the cpu: opcodes, operand bytes and
//   BUBBLE filler after two-cycle ops. A halt opcode (upper nibble F) or
//   running off the end of the store finishes the run.
//
// Ports
//   i_clk    - rising-edge clock
//   i_reset  - synchronous active-high reset (program store is kept)
//   s_if     - slave modport: load_en/load_addr/load_data/start in,
//              busy/done/overflow/pc/cpu_reset/cpu_in out (all registered)
//   o_state  - debug view of the FSM state encoding
//
// Build option
//   SEQ_LOOP_EN : when defined, halt restarts the program at pc=0 and the
//                 program counter wraps modulo the store depth; done and
//                 overflow are never set and only reset stops execution.
module cpu_prog_sequencer #(
  parameter int          ADDR_W = 4,
  parameter logic [7:0]  BUBBLE = 8'hF0
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  cpu_prog_sequencer_if.slave   s_if,
  output logic [2:0]            o_state
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CLR  = 3'd1,
    S_OPC  = 3'd2,
    S_OPR  = 3'd3,
    S_BUB  = 3'd4,
    S_DONE = 3'd5
  } state_t;

  state_t            r_state;
  logic [7:0]        r_prog [DEPTH];
  // One extra bit above the address: set once the pc has stepped past the
  // last word, which is how a missing halt is detected.
  logic [ADDR_W:0]   r_pc;
  logic              r_busy;
  logic              r_done;
  logic              r_overflow;
  logic              r_cpu_reset;
  logic [7:0]        r_cpu_in;

  logic [ADDR_W-1:0] w_pc_lo;
  logic [ADDR_W-1:0] w_pc_lo_inc;
  logic [ADDR_W:0]   w_pc_inc;
  logic [7:0]        w_word;
  logic              w_past_end;

  assign w_pc_lo     = r_pc[ADDR_W-1:0];
  assign w_pc_lo_inc = w_pc_lo + ADDR_W'(1);
  assign w_word      = r_prog[w_pc_lo];
  assign w_past_end  = r_pc[ADDR_W];

`ifdef SEQ_LOOP_EN
  // Plain modulo-DEPTH counting: the past-end bit never gets set.
  assign w_pc_inc = {1'b0, w_pc_lo_inc};
`else
  assign w_pc_inc = r_pc + (ADDR_W+1)'(1);
`endif

  // Program store write port. Writes land on the same edge that samples a
  // start, so a word written together with start is fetched one edge later.
  always_ff @(posedge i_clk) begin
    if (s_if.load_en && !r_busy) begin
      r_prog[s_if.load_addr] <= s_if.load_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_pc        <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_overflow  <= 1'b0;
      r_cpu_reset <= 1'b0;
      r_cpu_in    <= BUBBLE;
    end else begin
      r_cpu_reset <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          r_cpu_in <= BUBBLE;
          if (s_if.start) begin
            r_state     <= S_CLR;
            r_pc        <= '0;
            r_busy      <= 1'b1;
            r_done      <= 1'b0;
            r_overflow  <= 1'b0;
            r_cpu_reset <= 1'b1;
          end
        end

        // The cpu_reset cycle already performs the first fetch so prog[0]
        // reaches the cpu on the edge right after the reset pulse.
        S_CLR, S_OPC: begin
          if (w_past_end) begin
            r_cpu_in   <= BUBBLE;
            r_overflow <= 1'b1;
            r_done     <= 1'b1;
            r_busy     <= 1'b0;
            r_state    <= S_DONE;
          end else begin
            case (w_word[7:4])
              4'h6, 4'h7, 4'h8: begin
                r_cpu_in <= w_word;
                r_pc     <= w_pc_inc;
                r_state  <= S_OPR;
              end
              4'hA, 4'hC: begin
                r_cpu_in <= w_word;
                r_pc     <= w_pc_inc;
                r_state  <= S_BUB;
              end
              4'hF: begin
                r_cpu_in <= BUBBLE;
`ifdef SEQ_LOOP_EN
                r_pc     <= '0;
                r_state  <= S_OPC;
`else
                r_done   <= 1'b1;
                r_busy   <= 1'b0;
                r_state  <= S_DONE;
`endif
              end
              default: begin
                r_cpu_in <= w_word;
                r_pc     <= w_pc_inc;
                r_state  <= S_OPC;
              end
            endcase
          end
        end

        // Operand bytes are passed through verbatim, never decoded.
        S_OPR: begin
          if (w_past_end) begin
            r_cpu_in   <= BUBBLE;
            r_overflow <= 1'b1;
            r_done     <= 1'b1;
            r_busy     <= 1'b0;
            r_state    <= S_DONE;
          end else begin
            r_cpu_in <= w_word;
            r_pc     <= w_pc_inc;
            r_state  <= S_OPC;
          end
        end

        S_BUB: begin
          r_cpu_in <= BUBBLE;
          r_state  <= S_OPC;
        end

        default: begin
          r_cpu_in <= BUBBLE;
          r_busy   <= 1'b0;
          r_state  <= S_IDLE;
        end
      endcase
    end
  end

  assign s_if.busy      = r_busy;
  assign s_if.done      = r_done;
  assign s_if.overflow  = r_overflow;
  assign s_if.pc        = w_pc_lo;
  assign s_if.cpu_reset = r_cpu_reset;
  assign s_if.cpu_in    = r_cpu_in;
  assign o_state        = r_state;

endmodule
